// File: rtl/multi_mode_ff_bank_if.sv
// Bus bundle for multi_mode_ff_bank. The master drives the controls and flip-flop inputs.
// The slave returns the registered state and the error status.
interface multi_mode_ff_bank_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] inval;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output en, mode, a, b, err_clr,
    input  q, qb, inval, err_sticky, err_cnt
  );

  modport slave (
    input  en, mode, a, b, err_clr,
    output q, qb, inval, err_sticky, err_cnt
  );
endinterface

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit bank of flip-flops with run-time SR/JK/D/T mode selection.
// SR 11 inputs are resolved by SR_INVALID and reported through inval and the error counter.
module multi_mode_ff_bank #(
  parameter int unsigned       WIDTH      = 4,
  parameter logic [WIDTH-1:0]  RST_VAL    = '0,
  parameter int unsigned       SR_INVALID = 0,
  parameter int unsigned       CNT_W      = 8
) (
  input logic                 clk,
  input logic                 rst,
  multi_mode_ff_bank_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] inval_r;
  logic [WIDTH-1:0] inval_next;
  logic             any_inval;
  logic             sticky_r;
  logic [CNT_W-1:0] cnt_r;

  assign mode_s = mode_e'(bus.mode);

  always_comb begin
    q_next     = q_r;
    inval_next = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      unique case (mode_s)
        MODE_SR: begin
          unique case ({bus.a[i], bus.b[i]})
            2'b00: q_next[i] = q_r[i];
            2'b01: q_next[i] = 1'b0;
            2'b10: q_next[i] = 1'b1;
            2'b11: begin
              inval_next[i] = bus.en;
              unique case (SR_INVALID)
                1:       q_next[i] = 1'b0;
                2:       q_next[i] = 1'b1;
                3:       q_next[i] = ~q_r[i];
                default: q_next[i] = q_r[i];
              endcase
            end
          endcase
        end
        MODE_JK: begin
          unique case ({bus.a[i], bus.b[i]})
            2'b00: q_next[i] = q_r[i];
            2'b01: q_next[i] = 1'b0;
            2'b10: q_next[i] = 1'b1;
            2'b11: q_next[i] = ~q_r[i];
          endcase
        end
        MODE_D:  q_next[i] = bus.a[i];
        MODE_T:  q_next[i] = bus.a[i] ? ~q_r[i] : q_r[i];
      endcase
    end
  end

  assign any_inval = |inval_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r      <= RST_VAL;
      inval_r  <= '0;
      sticky_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      if (bus.en) begin
        q_r     <= q_next;
        inval_r <= inval_next;
      end else begin
        inval_r <= '0;
      end
      // A clear coinciding with an invalid event restarts the count at one.
      if (bus.err_clr) begin
        sticky_r <= any_inval;
        cnt_r    <= any_inval ? CNT_W'(1) : '0;
      end else if (any_inval) begin
        sticky_r <= 1'b1;
        if (cnt_r != '1) cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.q          = q_r;
  assign bus.qb         = ~q_r;
  assign bus.inval      = inval_r;
  assign bus.err_sticky = sticky_r;
  assign bus.err_cnt    = cnt_r;

endmodule
